snitch_icache_miss_queue: RTL and testbench

Per-line miss tracking stage between the icache lookup stage and the refill engine. It consumes every lookup result and returns hits to the fetch side immediately. Each new missing line gets a pending entry and a refill request. Later misses to an in-flight line merge into its entry. On refill return it answers all waiting requesters at once and writes the line back into the lookup RAMs.

---
 rtl/snitch_icache_miss_queue.sv | 208 ++++++++++++++++++++
 tb/tb_snitch_icache_miss_queue.sv | 518 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_icache_miss_queue.sv
// Miss tracking stage between icache lookup and refill engine: hits pass straight through,
// misses get a pending entry and a refill request. Define SNITCH_ICACHE_MISS_MERGE_EN to merge secondary misses.
module snitch_icache_miss_queue #(
  parameter int FETCH_AW      = 32,
  parameter int LINE_WIDTH    = 128,
  parameter int LINE_ALIGN    = 4,
  parameter int COUNT_ALIGN   = 7,
  parameter int SET_COUNT     = 2,
  parameter int SET_ALIGN     = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1,
  parameter int TAG_WIDTH     = FETCH_AW - LINE_ALIGN - COUNT_ALIGN,
  parameter int ID_WIDTH      = 4,
  parameter int PENDING_COUNT = 2,
  parameter int PIDX          = (PENDING_COUNT > 1) ? $clog2(PENDING_COUNT) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_valid_i,
  output logic                   flush_ready_o,
  input  logic [FETCH_AW-1:0]    in_addr_i,
  input  logic [ID_WIDTH-1:0]    in_id_i,
  input  logic [SET_ALIGN-1:0]   in_set_i,
  input  logic                   in_hit_i,
  input  logic                   in_error_i,
  input  logic [LINE_WIDTH-1:0]  in_data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [LINE_WIDTH-1:0]  rsp_data_o,
  output logic                   rsp_error_o,
  output logic [ID_WIDTH-1:0]    rsp_id_o,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [FETCH_AW-1:0]    refill_addr_o,
  output logic [PIDX-1:0]        refill_pending_o,
  output logic                   refill_valid_o,
  input  logic                   refill_ready_i,
  input  logic [LINE_WIDTH-1:0]  refill_data_i,
  input  logic                   refill_error_i,
  input  logic [PIDX-1:0]        refill_pending_i,
  input  logic                   refill_valid_i,
  output logic                   refill_ready_o,
  output logic [COUNT_ALIGN-1:0] write_addr_o,
  output logic [SET_ALIGN-1:0]   write_set_o,
  output logic [TAG_WIDTH-1:0]   write_tag_o,
  output logic [LINE_WIDTH-1:0]  write_data_o,
  output logic                   write_error_o,
  output logic                   write_valid_o,
  input  logic                   write_ready_i
);

  localparam int LINE_BITS = FETCH_AW - LINE_ALIGN;

  logic [PENDING_COUNT-1:0] valid_q, valid_d;
  logic [LINE_BITS-1:0]     line_q   [PENDING_COUNT];
  logic [LINE_BITS-1:0]     line_d   [PENDING_COUNT];
  logic [ID_WIDTH-1:0]      idmask_q [PENDING_COUNT];
  logic [ID_WIDTH-1:0]      idmask_d [PENDING_COUNT];
  logic                     req_valid_q, req_valid_d;
  logic [LINE_BITS-1:0]     req_line_q, req_line_d;
  logic [PIDX-1:0]          req_idx_q, req_idx_d;
  logic [SET_ALIGN-1:0]     way_q, way_d;

  logic [LINE_BITS-1:0] in_line, ret_line;
  logic [ID_WIDTH-1:0]  ret_idmask;
  logic [PIDX-1:0]      match_idx, free_idx;
  logic                 match_any, free_any;
  logic                 is_hit, is_miss, req_free;
  logic                 do_merge, do_alloc, retire_hs, flush_hs, flush_ready;
  logic                 unused_in;

  assign in_line     = in_addr_i[FETCH_AW-1:LINE_ALIGN];
  assign ret_line    = line_q[refill_pending_i];
  assign ret_idmask  = idmask_q[refill_pending_i];
  assign unused_in   = ^{in_set_i, in_addr_i[LINE_ALIGN-1:0]};
  assign flush_ready = ~rst_i & ~|valid_q & ~req_valid_q;

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    for (int i = PENDING_COUNT - 1; i >= 0; i--) begin
      if (valid_q[i] && (line_q[i] == in_line)) begin
        match_any = 1'b1;
        match_idx = PIDX'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = PIDX'(i);
      end
    end
  end

  always_comb begin
    is_hit    = in_valid_i & in_hit_i;
    is_miss   = in_valid_i & ~in_hit_i;
    req_free  = ~req_valid_q | refill_ready_i;
`ifdef SNITCH_ICACHE_MISS_MERGE_EN
    do_merge  = ~rst_i & is_miss & match_any &
                ~(refill_valid_i & (match_idx == refill_pending_i));
`else
    do_merge  = 1'b0;
`endif
    do_alloc  = ~rst_i & is_miss & ~match_any & free_any & req_free;
    retire_hs = ~rst_i & refill_valid_i & rsp_ready_i & write_ready_i;
    flush_hs  = flush_valid_i & flush_ready;
  end

  // Freed entries only show up as free after the edge, so retire and allocate never collide.
  always_comb begin
    valid_d     = valid_q;
    line_d      = line_q;
    idmask_d    = idmask_q;
    req_valid_d = req_valid_q;
    req_line_d  = req_line_q;
    req_idx_d   = req_idx_q;
    way_d       = way_q;
    if (retire_hs) begin
      valid_d[refill_pending_i] = 1'b0;
      way_d = (way_q == SET_ALIGN'(SET_COUNT - 1)) ? '0 : way_q + SET_ALIGN'(1);
    end
    if (flush_hs) begin
      way_d = '0;
    end
    if (do_merge) begin
      idmask_d[match_idx] = idmask_q[match_idx] | in_id_i;
    end
    if (do_alloc) begin
      valid_d[free_idx]  = 1'b1;
      line_d[free_idx]   = in_line;
      idmask_d[free_idx] = in_id_i;
      req_valid_d        = 1'b1;
      req_line_d         = in_line;
      req_idx_d          = free_idx;
    end else if (refill_ready_i) begin
      req_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      req_valid_q <= 1'b0;
      req_line_q  <= '0;
      req_idx_q   <= '0;
      way_q       <= '0;
      for (int i = 0; i < PENDING_COUNT; i++) begin
        line_q[i]   <= '0;
        idmask_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      line_q      <= line_d;
      idmask_q    <= idmask_d;
      req_valid_q <= req_valid_d;
      req_line_q  <= req_line_d;
      req_idx_q   <= req_idx_d;
      way_q       <= way_d;
    end
  end

  // A returning refill owns the response port; a hit only gets it when no refill is presented.
  always_comb begin
    flush_ready_o    = flush_ready;
    in_ready_o       = 1'b0;
    rsp_data_o       = '0;
    rsp_error_o      = 1'b0;
    rsp_id_o         = '0;
    rsp_valid_o      = 1'b0;
    refill_addr_o    = '0;
    refill_pending_o = '0;
    refill_valid_o   = 1'b0;
    refill_ready_o   = 1'b0;
    write_addr_o     = '0;
    write_set_o      = '0;
    write_tag_o      = '0;
    write_data_o     = '0;
    write_error_o    = 1'b0;
    write_valid_o    = 1'b0;
    if (!rst_i) begin
      refill_valid_o   = req_valid_q;
      refill_addr_o    = {req_line_q, {LINE_ALIGN{1'b0}}};
      refill_pending_o = req_idx_q;
      in_ready_o       = is_hit ? (~refill_valid_i & rsp_ready_i) : (do_merge | do_alloc);
      if (refill_valid_i) begin
        rsp_data_o     = refill_data_i;
        rsp_error_o    = refill_error_i;
        rsp_id_o       = ret_idmask;
        rsp_valid_o    = write_ready_i;
        write_addr_o   = ret_line[COUNT_ALIGN-1:0];
        write_set_o    = way_q;
        write_tag_o    = ret_line[LINE_BITS-1:COUNT_ALIGN];
        write_data_o   = refill_data_i;
        write_error_o  = refill_error_i;
        write_valid_o  = rsp_ready_i;
        refill_ready_o = rsp_ready_i & write_ready_i;
      end else if (is_hit) begin
        rsp_data_o  = in_data_i;
        rsp_error_o = in_error_i;
        rsp_id_o    = in_id_i;
        rsp_valid_o = 1'b1;
      end
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i) refill_valid_i |-> valid_q[refill_pending_i]);

endmodule

// File: tb/tb_snitch_icache_miss_queue.sv
// Bench for snitch_icache_miss_queue: expected responses and refill requests are queued
// when stimulus is driven and popped when the DUT presents them.
module tb_snitch_icache_miss_queue;

  typedef struct {
    logic [3:0]   id;
    logic [127:0] data;
    logic         err;
    logic [31:0]  addr;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic        idx;
  } req_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         flushValid, flushReady;
  logic [31:0]  inAddr;
  logic [3:0]   inId;
  logic [0:0]   inSet;
  logic         inHit, inError, inValid, inReady;
  logic [127:0] inData;
  logic [127:0] rspData;
  logic         rspError, rspValid, rspReady;
  logic [3:0]   rspId;
  logic [31:0]  refillAddr;
  logic         refillPendingO, refillValidO, refillReadyI;
  logic [127:0] refillData;
  logic         refillError, refillPendingI, refillValidI, refillReadyO;
  logic [6:0]   writeAddr;
  logic [0:0]   writeSet;
  logic [20:0]  writeTag;
  logic [127:0] writeData;
  logic         writeError, writeValid, writeReady;

  rsp_t expRsp[$];
  req_t expReq[$];
  int   total = 0;
  int   bad = 0;
  int   expWay = 0;

  always #5 clk = ~clk;

  snitch_icache_miss_queue dut (
    .clk_i(clk), .rst_i(rst),
    .flush_valid_i(flushValid), .flush_ready_o(flushReady),
    .in_addr_i(inAddr), .in_id_i(inId), .in_set_i(inSet), .in_hit_i(inHit),
    .in_error_i(inError), .in_data_i(inData), .in_valid_i(inValid), .in_ready_o(inReady),
    .rsp_data_o(rspData), .rsp_error_o(rspError), .rsp_id_o(rspId),
    .rsp_valid_o(rspValid), .rsp_ready_i(rspReady),
    .refill_addr_o(refillAddr), .refill_pending_o(refillPendingO),
    .refill_valid_o(refillValidO), .refill_ready_i(refillReadyI),
    .refill_data_i(refillData), .refill_error_i(refillError),
    .refill_pending_i(refillPendingI), .refill_valid_i(refillValidI), .refill_ready_o(refillReadyO),
    .write_addr_o(writeAddr), .write_set_o(writeSet), .write_tag_o(writeTag),
    .write_data_o(writeData), .write_error_o(writeError),
    .write_valid_o(writeValid), .write_ready_i(writeReady)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic driveMiss(input logic [31:0] addr, input logic [3:0] id);
    inValid = 1'b1; inHit = 1'b0; inAddr = addr; inId = id; inError = 1'b0; inData = '0;
  endtask

  task automatic driveHit(input logic [31:0] addr, input logic [3:0] id, input logic [127:0] data);
    inValid = 1'b1; inHit = 1'b1; inAddr = addr; inId = id; inError = 1'b0; inData = data;
  endtask

  task automatic driveReturn(input logic idx, input logic [127:0] data, input logic err);
    refillValidI = 1'b1; refillPendingI = idx; refillData = data; refillError = err;
  endtask

  task automatic test_reset();
    rsp_t e;
    rst = 1'b1; flushValid = 1'b0; inSet = '0; rspReady = 1'b1; writeReady = 1'b1;
    refillReadyI = 1'b0; refillValidI = 1'b0; refillPendingI = 1'b0; refillData = '0; refillError = 1'b0;
    e.data = {4{32'hCAFE_F00D}};
    driveHit(32'h1000, 4'b0001, e.data);
    step();
    step();
    total++;
    if ({inReady, rspValid, refillValidO, flushReady, writeValid, refillReadyO, rspData, rspId} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got in_ready=%0b rsp_valid=%0b refill_valid=%0b flush_ready=%0b rsp_data=%h want all zero",
               inReady, rspValid, refillValidO, flushReady, rspData);
    end
    inValid = 1'b0;
    rst = 1'b0;
    step();
    total++;
    if ({flushReady, refillValidO, rspValid} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL reset_release got flush_ready=%0b refill_valid=%0b rsp_valid=%0b want 1 0 0",
               flushReady, refillValidO, rspValid);
    end
  endtask

  task automatic test_hit();
    rsp_t e;
    step();
    e.id = 4'b0001; e.data = {4{32'hD00D_1234}}; e.err = 1'b0; e.addr = 32'h1000;
    driveHit(e.addr, e.id, e.data);
    expRsp.push_back(e);
    #1;
    e = expRsp.pop_front();
    total++;
    if ({rspValid, rspId, rspData, rspError, inReady, refillValidO} !== {1'b1, e.id, e.data, e.err, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL hit_rsp got v=%0b id=%h data=%h rdy=%0b want v=1 id=%h data=%h rdy=1",
               rspValid, rspId, rspData, inReady, e.id, e.data);
    end
    step();
    inValid = 1'b0;
    #1;
    total++;
    if (refillValidO !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hit_no_refill got refill_valid=%0b want 0", refillValidO);
    end
  endtask

  task automatic test_miss();
    rsp_t e;
    req_t r;
    step();
    driveMiss(32'h2004, 4'b0010);
    expReq.push_back('{addr: 32'h2000, idx: 1'b0});
    expRsp.push_back('{id: 4'b0010, data: {4{32'hEEEE_0001}}, err: 1'b0, addr: 32'h2000});
    #1;
    total++;
    if ({inReady, rspValid} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL miss_accept got in_ready=%0b rsp_valid=%0b want 1 0", inReady, rspValid);
    end
    step();
    inValid = 1'b0;
    #1;
    r = expReq.pop_front();
    total++;
    if ({refillValidO, refillAddr, refillPendingO} !== {1'b1, r.addr, r.idx}) begin
      bad++;
      $display("[TB] FAIL miss_req got v=%0b addr=%h idx=%0d want v=1 addr=%h idx=%0d",
               refillValidO, refillAddr, refillPendingO, r.addr, r.idx);
    end
    step();
    total++;
    if ({refillValidO, refillAddr} !== {1'b1, 32'h2000}) begin
      bad++;
      $display("[TB] FAIL miss_req_hold got v=%0b addr=%h want v=1 addr=00002000", refillValidO, refillAddr);
    end
    refillReadyI = 1'b1;
    step();
    e = expRsp.pop_front();
    driveReturn(1'b0, e.data, e.err);
    #1;
    total++;
    if ({refillValidO, rspValid, rspId, rspData, rspError, writeValid, writeSet, writeAddr, writeTag, writeData, refillReadyO} !==
        {1'b0, 1'b1, e.id, e.data, e.err, 1'b1, expWay[0], e.addr[10:4], e.addr[31:11], e.data, 1'b1}) begin
      bad++;
      $display("[TB] FAIL miss_return got id=%h data=%h set=%h waddr=%h tag=%h want id=%h data=%h set=%h waddr=%h tag=%h",
               rspId, rspData, writeSet, writeAddr, writeTag, e.id, e.data, expWay[0], e.addr[10:4], e.addr[31:11]);
    end
    step();
    refillValidI = 1'b0;
    expWay = (expWay + 1) % 2;
  endtask

  task automatic test_merge();
    rsp_t e;
    req_t r;
    driveMiss(32'h3000, 4'b0001);
    expReq.push_back('{addr: 32'h3000, idx: 1'b0});
`ifdef SNITCH_ICACHE_MISS_MERGE_EN
    expRsp.push_back('{id: 4'b0101, data: {4{32'hF0F0_0003}}, err: 1'b0, addr: 32'h3000});
`else
    expRsp.push_back('{id: 4'b0001, data: {4{32'hF0F0_0003}}, err: 1'b0, addr: 32'h3000});
`endif
    step();
    driveMiss(32'h3008, 4'b0100);
    #1;
    r = expReq.pop_front();
    total++;
    if ({refillValidO, refillAddr, refillPendingO} !== {1'b1, r.addr, r.idx}) begin
      bad++;
      $display("[TB] FAIL merge_req got v=%0b addr=%h idx=%0d want v=1 addr=%h idx=%0d",
               refillValidO, refillAddr, refillPendingO, r.addr, r.idx);
    end
`ifdef SNITCH_ICACHE_MISS_MERGE_EN
    total++;
    if (inReady !== 1'b1) begin
      bad++;
      $display("[TB] FAIL merge_accept got in_ready=%0b want 1", inReady);
    end
    step();
    inValid = 1'b0;
`else
    total++;
    if (inReady !== 1'b0) begin
      bad++;
      $display("[TB] FAIL nomerge_stall got in_ready=%0b want 0", inReady);
    end
    step();
`endif
    e = expRsp.pop_front();
    driveReturn(1'b0, e.data, e.err);
    #1;
    total++;
    if ({inReady, refillValidO, rspValid, rspId, rspData, writeValid, writeSet, writeAddr, writeTag} !==
        {1'b0, 1'b0, 1'b1, e.id, e.data, 1'b1, expWay[0], e.addr[10:4], e.addr[31:11]}) begin
      bad++;
      $display("[TB] FAIL merge_return got rdy=%0b req=%0b id=%h data=%h set=%h want rdy=0 req=0 id=%h data=%h set=%h",
               inReady, refillValidO, rspId, rspData, writeSet, e.id, e.data, expWay[0]);
    end
    step();
    refillValidI = 1'b0;
    expWay = (expWay + 1) % 2;
`ifndef SNITCH_ICACHE_MISS_MERGE_EN
    #1;
    total++;
    if (inReady !== 1'b1) begin
      bad++;
      $display("[TB] FAIL nomerge_realloc got in_ready=%0b want 1", inReady);
    end
    expReq.push_back('{addr: 32'h3000, idx: 1'b0});
    expRsp.push_back('{id: 4'b0100, data: {4{32'h0303_0303}}, err: 1'b0, addr: 32'h3000});
    step();
    inValid = 1'b0;
    #1;
    r = expReq.pop_front();
    total++;
    if ({refillValidO, refillAddr, refillPendingO} !== {1'b1, r.addr, r.idx}) begin
      bad++;
      $display("[TB] FAIL nomerge_req2 got v=%0b addr=%h idx=%0d want v=1 addr=%h idx=%0d",
               refillValidO, refillAddr, refillPendingO, r.addr, r.idx);
    end
    step();
    e = expRsp.pop_front();
    driveReturn(1'b0, e.data, e.err);
    #1;
    total++;
    if ({rspValid, rspId, rspData, writeValid, writeSet} !== {1'b1, e.id, e.data, 1'b1, expWay[0]}) begin
      bad++;
      $display("[TB] FAIL nomerge_return2 got id=%h data=%h set=%h want id=%h data=%h set=%h",
               rspId, rspData, writeSet, e.id, e.data, expWay[0]);
    end
    step();
    refillValidI = 1'b0;
    expWay = (expWay + 1) % 2;
`endif
  endtask

  task automatic test_full();
    rsp_t e;
    req_t r;
    logic [31:0] addrs [3];
    logic [3:0]  ids [3];
    logic        errs [3];
    addrs = '{32'h4000, 32'h5000, 32'h6000};
    ids   = '{4'b0001, 4'b0010, 4'b1000};
    errs  = '{1'b0, 1'b1, 1'b0};
    step();
    for (int k = 0; k < 3; k++) begin
      driveMiss(addrs[k], ids[k]);
      #1;
      total++;
      if (inReady !== (k < 2)) begin
        bad++;
        $display("[TB] FAIL full_accept%0d got in_ready=%0b want %0b", k, inReady, (k < 2));
      end
      if (k < 2) begin
        expReq.push_back('{addr: addrs[k], idx: 1'(k)});
        expRsp.push_back('{id: ids[k], data: {4{8'(k + 8'hA0), 24'h00_5A5A}}, err: errs[k], addr: addrs[k]});
      end
      if (k > 0) begin
        r = expReq.pop_front();
        total++;
        if ({refillValidO, refillAddr, refillPendingO} !== {1'b1, r.addr, r.idx}) begin
          bad++;
          $display("[TB] FAIL full_req%0d got v=%0b addr=%h idx=%0d want v=1 addr=%h idx=%0d",
                   k, refillValidO, refillAddr, refillPendingO, r.addr, r.idx);
        end
      end
      step();
    end
    e = expRsp.pop_front();
    driveReturn(1'b0, e.data, e.err);
    #1;
    total++;
    if ({inReady, refillValidO, rspValid, rspId, rspData, rspError, writeSet, writeTag} !==
        {1'b0, 1'b0, 1'b1, e.id, e.data, e.err, expWay[0], e.addr[31:11]}) begin
      bad++;
      $display("[TB] FAIL full_return0 got rdy=%0b id=%h data=%h set=%h tag=%h want rdy=0 id=%h data=%h set=%h tag=%h",
               inReady, rspId, rspData, writeSet, writeTag, e.id, e.data, expWay[0], e.addr[31:11]);
    end
    step();
    refillValidI = 1'b0;
    expWay = (expWay + 1) % 2;
    #1;
    total++;
    if (inReady !== 1'b1) begin
      bad++;
      $display("[TB] FAIL full_reuse_accept got in_ready=%0b want 1", inReady);
    end
    expReq.push_back('{addr: 32'h6000, idx: 1'b0});
    expRsp.push_back('{id: ids[2], data: {4{32'hA2A2_5A5A}}, err: 1'b0, addr: 32'h6000});
    step();
    inValid = 1'b0;
    #1;
    r = expReq.pop_front();
    total++;
    if ({refillValidO, refillAddr, refillPendingO} !== {1'b1, r.addr, r.idx}) begin
      bad++;
      $display("[TB] FAIL full_reuse_req got v=%0b addr=%h idx=%0d want v=1 addr=%h idx=%0d",
               refillValidO, refillAddr, refillPendingO, r.addr, r.idx);
    end
    for (int k = 1; k >= 0; k--) begin
      step();
      e = expRsp.pop_front();
      driveReturn(1'(k), e.data, e.err);
      #1;
      total++;
      if ({rspValid, rspId, rspData, rspError, writeError, writeValid, writeSet, writeAddr, writeTag} !==
          {1'b1, e.id, e.data, e.err, e.err, 1'b1, expWay[0], e.addr[10:4], e.addr[31:11]}) begin
        bad++;
        $display("[TB] FAIL full_return_idx%0d got id=%h data=%h err=%0b set=%h tag=%h want id=%h data=%h err=%0b set=%h tag=%h",
                 k, rspId, rspData, rspError, writeSet, writeTag, e.id, e.data, e.err, expWay[0], e.addr[31:11]);
      end
      step();
      refillValidI = 1'b0;
      expWay = (expWay + 1) % 2;
    end
  endtask

  task automatic test_collision();
    rsp_t e;
    rsp_t h;
    req_t r;
    logic [31:0] addr;
    flushValid = 1'b1;
    #1;
    total++;
    if (flushReady !== 1'b1) begin
      bad++;
      $display("[TB] FAIL collision_flush_ready got %0b want 1", flushReady);
    end
    step();
    flushValid = 1'b0;
    expWay = 0;
    for (int k = 0; k < 4; k++) begin
      addr = 32'h7000 + 32'(k) * 32'h1000;
      driveMiss(addr, 4'(1 << k));
      expReq.push_back('{addr: addr, idx: 1'b0});
      expRsp.push_back('{id: 4'(1 << k), data: {4{8'(k), 24'hC011DE}}, err: 1'b0, addr: addr});
      step();
      inValid = 1'b0;
      #1;
      r = expReq.pop_front();
      total++;
      if ({refillValidO, refillAddr, refillPendingO} !== {1'b1, r.addr, r.idx}) begin
        bad++;
        $display("[TB] FAIL collision_req%0d got v=%0b addr=%h idx=%0d want v=1 addr=%h idx=%0d",
                 k, refillValidO, refillAddr, refillPendingO, r.addr, r.idx);
      end
      step();
      e = expRsp.pop_front();
      driveReturn(1'b0, e.data, e.err);
      h.id = 4'b0010; h.data = {4{32'h1111_2222}}; h.err = 1'b0; h.addr = 32'h1000;
      if (k == 0) driveHit(h.addr, h.id, h.data);
      #1;
      total++;
      if ({inReady, rspValid, rspId, rspData, writeValid, writeSet} !== {1'b0, 1'b1, e.id, e.data, 1'b1, expWay[0]}) begin
        bad++;
        $display("[TB] FAIL collision_return%0d got rdy=%0b id=%h data=%h set=%h want rdy=0 id=%h data=%h set=%h",
                 k, inReady, rspId, rspData, writeSet, e.id, e.data, expWay[0]);
      end
      step();
      refillValidI = 1'b0;
      expWay = (expWay + 1) % 2;
      if (k == 0) begin
        expRsp.push_back(h);
        #1;
        h = expRsp.pop_front();
        total++;
        if ({inReady, rspValid, rspId, rspData} !== {1'b1, 1'b1, h.id, h.data}) begin
          bad++;
          $display("[TB] FAIL collision_hit_after got rdy=%0b v=%0b id=%h data=%h want rdy=1 v=1 id=%h data=%h",
                   inReady, rspValid, rspId, rspData, h.id, h.data);
        end
        step();
        inValid = 1'b0;
      end
    end
  endtask

  task automatic test_flush();
    rsp_t e;
    driveMiss(32'hB000, 4'b0001);
    expRsp.push_back('{id: 4'b0001, data: {4{32'hBBBB_0000}}, err: 1'b0, addr: 32'hB000});
    step();
    inValid = 1'b0;
    flushValid = 1'b1;
    #1;
    total++;
    if ({flushReady, refillValidO} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL flush_busy_req got flush_ready=%0b refill_valid=%0b want 0 1", flushReady, refillValidO);
    end
    step();
    e = expRsp.pop_front();
    driveReturn(1'b0, e.data, e.err);
    #1;
    total++;
    if ({flushReady, rspValid, rspId, writeSet} !== {1'b0, 1'b1, e.id, expWay[0]}) begin
      bad++;
      $display("[TB] FAIL flush_busy_return got flush_ready=%0b id=%h set=%h want 0 id=%h set=%h",
               flushReady, rspId, writeSet, e.id, expWay[0]);
    end
    step();
    refillValidI = 1'b0;
    expWay = (expWay + 1) % 2;
    #1;
    total++;
    if (flushReady !== 1'b1) begin
      bad++;
      $display("[TB] FAIL flush_ready_idle got %0b want 1", flushReady);
    end
    step();
    flushValid = 1'b0;
    expWay = 0;
    driveMiss(32'hC000, 4'b0010);
    expRsp.push_back('{id: 4'b0010, data: {4{32'hCCCC_0000}}, err: 1'b0, addr: 32'hC000});
    step();
    inValid = 1'b0;
    step();
    e = expRsp.pop_front();
    driveReturn(1'b0, e.data, e.err);
    #1;
    total++;
    if ({rspValid, rspId, writeValid, writeSet, writeTag} !== {1'b1, e.id, 1'b1, expWay[0], e.addr[31:11]}) begin
      bad++;
      $display("[TB] FAIL flush_way_reset got id=%h set=%h tag=%h want id=%h set=%h tag=%h",
               rspId, writeSet, writeTag, e.id, expWay[0], e.addr[31:11]);
    end
    step();
    refillValidI = 1'b0;
    expWay = (expWay + 1) % 2;
  endtask

  task automatic test_reset_mid();
    rsp_t e;
    req_t r;
    driveMiss(32'hD000, 4'b0100);
    step();
    inValid = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({refillValidO, flushReady, inReady} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL reset_mid_outputs got refill_valid=%0b flush_ready=%0b in_ready=%0b want 0 0 0",
               refillValidO, flushReady, inReady);
    end
    step();
    rst = 1'b0;
    expWay = 0;
    #1;
    total++;
    if ({flushReady, refillValidO} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL reset_mid_dropped got flush_ready=%0b refill_valid=%0b want 1 0", flushReady, refillValidO);
    end
    driveMiss(32'hE010, 4'b1000);
    expReq.push_back('{addr: 32'hE010, idx: 1'b0});
    expRsp.push_back('{id: 4'b1000, data: {4{32'hEEEE_1111}}, err: 1'b0, addr: 32'hE010});
    step();
    inValid = 1'b0;
    #1;
    r = expReq.pop_front();
    total++;
    if ({refillValidO, refillAddr, refillPendingO} !== {1'b1, r.addr, r.idx}) begin
      bad++;
      $display("[TB] FAIL reset_mid_req got v=%0b addr=%h idx=%0d want v=1 addr=%h idx=%0d",
               refillValidO, refillAddr, refillPendingO, r.addr, r.idx);
    end
    step();
    e = expRsp.pop_front();
    driveReturn(1'b0, e.data, e.err);
    #1;
    total++;
    if ({rspValid, rspId, rspData, writeSet, writeAddr} !== {1'b1, e.id, e.data, expWay[0], e.addr[10:4]}) begin
      bad++;
      $display("[TB] FAIL reset_mid_return got id=%h data=%h set=%h waddr=%h want id=%h data=%h set=%h waddr=%h",
               rspId, rspData, writeSet, writeAddr, e.id, e.data, expWay[0], e.addr[10:4]);
    end
    step();
    refillValidI = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_merge();
    test_full();
    test_collision();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
